// File: rtl/blink_scheduler.sv
// blink_scheduler: round-robin owner of a 4-digit blink resource.
// Optional idle timeout with lockout enabled by BLINK_TIMEOUT_EN.
module blink_scheduler #(
  parameter int HALF_PERIOD    = 500,
  parameter int SLOT_PHASES    = 4,
  parameter int TIMEOUT_PHASES = 20
) (
  input  logic       clk,
  input  logic       reset_n_wire,
  input  logic       enable_wire,
  input  logic [3:0] req_wire,
  input  logic       activity_wire,
  output logic [3:0] grant,
  output logic       blink,
  output logic [3:0] blank,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    LOCKOUT
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic       blink_q, blink_d;
  logic [9:0] phase_q, phase_d;
  logic [3:0] slot_q, slot_d;
  logic [1:0] last_q, last_d;
  logic       timeout_q, timeout_d;
  logic [3:0] pick;
  logic [3:0] other;
  logic [3:0] slot_nx;
  logic       wrap;

`ifdef BLINK_TIMEOUT_EN
  logic [7:0] idle_q, idle_d;
`else
  logic       unused_activity;
  assign unused_activity = activity_wire;
`endif

  // First requester strictly after last, wrapping; last itself checked last
  function automatic logic [3:0] rr_pick(
    input logic [3:0] req,
    input logic [1:0] last
  );
    logic [3:0] g;
    logic [1:0] idx;
    g = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) g = 4'b0001 << idx;
    end
    return g;
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] g);
    return {g[3] | g[2], g[3] | g[1]};
  endfunction

  assign pick    = rr_pick(req_wire, last_q);
  assign other   = rr_pick(req_wire & ~grant_q, last_q);
  assign wrap    = (phase_q == 10'(HALF_PERIOD - 1));
  assign slot_nx = slot_q + 4'd1;

  // Next-state: arbitration, phase/slot counting, rotation, release
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    blink_d   = blink_q;
    phase_d   = phase_q;
    slot_d    = slot_q;
    last_d    = last_q;
    timeout_d = 1'b0;
`ifdef BLINK_TIMEOUT_EN
    idle_d    = idle_q;
`endif
    if (enable_wire) begin
      unique case (state_q)
        IDLE: begin
          if (|req_wire) begin
            state_d = GRANT;
            grant_d = pick;
            last_d  = enc(pick);
            phase_d = '0;
            slot_d  = '0;
            blink_d = 1'b0;
`ifdef BLINK_TIMEOUT_EN
            idle_d  = '0;
`endif
          end
        end
        GRANT: begin
          if (!(|(req_wire & grant_q))) begin
            state_d = IDLE;
            grant_d = '0;
            blink_d = 1'b0;
            phase_d = '0;
            slot_d  = '0;
          end else begin
            phase_d = phase_q + 10'd1;
`ifdef BLINK_TIMEOUT_EN
            if (activity_wire) idle_d = '0;
`endif
            if (wrap) begin
              phase_d = '0;
              blink_d = ~blink_q;
              slot_d  = slot_nx;
              if (slot_nx == 4'(SLOT_PHASES)) begin
                slot_d = '0;
                if (|other) begin
                  grant_d = other;
                  last_d  = enc(other);
                  blink_d = 1'b0;
`ifdef BLINK_TIMEOUT_EN
                  idle_d  = '0;
`endif
                end
              end
`ifdef BLINK_TIMEOUT_EN
              if (!activity_wire) begin
                idle_d = idle_q + 8'd1;
                if (idle_q + 8'd1 == 8'(TIMEOUT_PHASES)) begin
                  state_d   = LOCKOUT;
                  grant_d   = '0;
                  blink_d   = 1'b0;
                  phase_d   = '0;
                  slot_d    = '0;
                  idle_d    = '0;
                  timeout_d = 1'b1;
                end
              end
`endif
            end
          end
        end
        LOCKOUT: begin
          if (req_wire == 4'b0000) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset_n_wire) begin
    if (!reset_n_wire) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      blink_q   <= 1'b0;
      phase_q   <= '0;
      slot_q    <= '0;
      last_q    <= 2'd3;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
      slot_q    <= slot_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef BLINK_TIMEOUT_EN
  // Half-periods since last grant or user activity
  always_ff @(posedge clk or negedge reset_n_wire) begin
    if (!reset_n_wire) idle_q <= '0;
    else               idle_q <= idle_d;
  end
`endif

  assign grant   = grant_q;
  assign blink   = blink_q;
  assign blank   = grant_q & {4{blink_q}};
  assign busy    = (state_q == GRANT);
  assign timeout = timeout_q;

endmodule

// File: doc/blink_scheduler.md
BLINK_SCHEDULER -- requirements
Module: blink_scheduler

Interface
REQ-001 Parameter HALF_PERIOD, default 500, sets clk cycles per blink half-period (500 ms at 1 kHz); legal range 2..1023.
REQ-002 Parameter SLOT_PHASES, default 4, sets half-periods per grant slot before rotation; SHALL be even; legal range 2..15.
REQ-003 Parameter TIMEOUT_PHASES, default 20, sets half-periods without activity before forced release (BLINK_TIMEOUT_EN only).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset_n_wire  input  1  asynchronous, active-low reset.
REQ-006 enable_wire  input  1  high = scheduler runs; low = all counters and state frozen.
REQ-007 req_wire  input  4  per-digit blink requests, level-sensitive; bit i = digit i.
REQ-008 activity_wire  input  1  single-cycle user-activity pulse; restarts timeout count.
REQ-009 grant  output  4  one-hot current owner of the blink resource; 0 when idle.
REQ-010 blink  output  1  blink phase; 0 = digit shown, 1 = digit blanked.
REQ-011 blank  output  4  grant AND {4{blink}}; combinational from registers.
REQ-012 busy  output  1  high while any grant is held.
REQ-013 timeout  output  1  one-cycle pulse on forced release (0 without BLINK_TIMEOUT_EN).

Function
REQ-014 FSM SHALL have states IDLE, GRANT, LOCKOUT (LOCKOUT reachable only with BLINK_TIMEOUT_EN).
REQ-015 IDLE with enable_wire=1 and req_wire!=0: next edge -> GRANT; grant = first requester after last_owner, round-robin; last_owner resets to 3, so req 0 wins first.
REQ-016 In GRANT, 10-bit phase counter SHALL count 0..HALF_PERIOD-1; at terminal count it wraps to 0, blink toggles, slot_cnt increments.
REQ-017 First blink toggle after grant SHALL occur exactly HALF_PERIOD cycles after the grant edge.
REQ-018 When slot_cnt reaches SLOT_PHASES (blink then 0): if another req bit is set, grant SHALL move to the next round-robin requester on that edge, counters cleared; else the grant is kept and slot_cnt cleared.
REQ-019 If the granted req bit drops, next edge SHALL go IDLE, clearing grant, blink, phase and slot counters; last_owner keeps the released digit.
REQ-020 Release and new requests in the same cycle: IDLE for exactly one cycle, then arbitration per REQ-015.
REQ-021 enable_wire=0 SHALL freeze state, counters, blink, grant; req changes while frozen act on the first enabled edge.
REQ-022 busy = (state==GRANT); blank SHALL never have more than one bit set.

Reset
REQ-023 reset_n_wire low SHALL immediately force IDLE, grant=0, blink=0, blank=0, busy=0, timeout=0, counters 0, last_owner=3.
REQ-024 Reset mid-grant SHALL discard the slot; first edge after deassertion follows REQ-015.

Configuration
REQ-025 Macro BLINK_TIMEOUT_EN defined: idle counter clears on grant and activity_wire, increments per half-period; at TIMEOUT_PHASES -> LOCKOUT, grant/blink cleared, timeout pulses 1 cycle; LOCKOUT -> IDLE only once req_wire==0.
REQ-026 Macro BLINK_TIMEOUT_EN undefined: no idle counter or LOCKOUT state; timeout tied to 0; activity_wire ignored.

Verification
REQ-027 Reset held 10 cycles, req=4'b0001, enable=0 -> grant=0, blink=0, busy=0 throughout.
REQ-028 Release reset, enable=1, req=4'b0001 -> grant=4'b0001 on next edge; blink=1 after 500 further cycles; blank=4'b0001 while blink=1.
REQ-029 req=4'b0101 held, HALF_PERIOD=500 -> grant 0001 for 2000 cycles, then 0100 for 2000 cycles, then 0001; blink=0 at every handover.
REQ-030 Granted at blink=1, enable=0 for 10 cycles -> blink, grant unchanged; then reset_n_wire low -> blink=0, grant=0 immediately.
REQ-031 req=4'b0010 dropped mid-slot while req=4'b1000 rises -> one IDLE cycle (grant=0), then grant=4'b1000, blink=0.
REQ-032 BLINK_TIMEOUT_EN, TIMEOUT_PHASES=20, req=4'b0001, no activity -> timeout pulse at 10000 cycles, grant=0 until req=0 then re-request grants 0001.
